// File: rtl/nn_sequencer_if.sv
// rtl/nn_sequencer_if.sv - handshake and memory/datapath control bundle for nn_sequencer
interface nn_sequencer_if #(
    parameter int N_NEURON = 4,
    parameter int AW       = 8
);
    localparam int XW = $clog2(N_NEURON);

    logic          fill;
    logic          req;
    logic          ack_fill;
    logic          ack_network;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic [XW-1:0] x_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          act_en;
    logic          y_we;
    logic [XW-1:0] y_addr;
    logic          buf_sel;

    modport master (
        output fill, req,
        input  ack_fill, ack_network, w_addr, w_we, x_addr,
               mac_clr, mac_en, act_en, y_we, y_addr, buf_sel
    );

    modport slave (
        input  fill, req,
        output ack_fill, ack_network, w_addr, w_we, x_addr,
               mac_clr, mac_en, act_en, y_we, y_addr, buf_sel
    );
endinterface

// File: rtl/nn_sequencer.sv
// rtl/nn_sequencer.sv - weight-fill and layer/neuron/input compute sequencer for a square tanh MLP
module nn_sequencer #(
    parameter int N_NEURON = 4,
    parameter int N_LAYER  = 2,
    parameter int AW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    nn_sequencer_if.slave   bus
);
    localparam int XW        = $clog2(N_NEURON);
    localparam int LW        = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
    localparam int FILL_LAST = N_LAYER * N_NEURON * N_NEURON - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FDONE,
        S_MAC,
        S_ACT,
        S_WR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fcnt_q, fcnt_d;
    logic [LW-1:0] l_q, l_d;
    logic [XW-1:0] o_q, o_d;
    logic [XW-1:0] i_q, i_d;

    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [XW-1:0] x_addr_q, x_addr_d;
    logic [XW-1:0] y_addr_q, y_addr_d;
    logic          w_we_q, w_we_d;
    logic          mac_clr_q, mac_clr_d;
    logic          mac_en_q, mac_en_d;
    logic          act_en_q, act_en_d;
    logic          y_we_q, y_we_d;
    logic          buf_sel_q, buf_sel_d;
    logic          ack_fill_q, ack_fill_d;
    logic          ack_net_q, ack_net_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fcnt_q     <= '0;
            l_q        <= '0;
            o_q        <= '0;
            i_q        <= '0;
            w_addr_q   <= '0;
            x_addr_q   <= '0;
            y_addr_q   <= '0;
            w_we_q     <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            act_en_q   <= 1'b0;
            y_we_q     <= 1'b0;
            buf_sel_q  <= 1'b0;
            ack_fill_q <= 1'b0;
            ack_net_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            l_q        <= l_d;
            o_q        <= o_d;
            i_q        <= i_d;
            w_addr_q   <= w_addr_d;
            x_addr_q   <= x_addr_d;
            y_addr_q   <= y_addr_d;
            w_we_q     <= w_we_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            act_en_q   <= act_en_d;
            y_we_q     <= y_we_d;
            buf_sel_q  <= buf_sel_d;
            ack_fill_q <= ack_fill_d;
            ack_net_q  <= ack_net_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        l_d     = l_q;
        o_d     = o_q;
        i_d     = i_q;

        case (state_q)
            S_IDLE: begin
                fcnt_d = '0;
                l_d    = '0;
                o_d    = '0;
                i_d    = '0;
                if (bus.fill)     state_d = S_FILL;
                else if (bus.req) state_d = S_MAC;
            end
            S_FILL: begin
                if (!bus.fill) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else if (fcnt_q == AW'(FILL_LAST)) begin
                    state_d = S_FDONE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_FDONE: begin
                if (!bus.fill) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end
            end
            S_MAC, S_ACT, S_WR, S_DONE: begin
                if (!bus.req) begin
                    state_d = S_IDLE;
                    l_d     = '0;
                    o_d     = '0;
                    i_d     = '0;
                end else if (state_q == S_MAC) begin
                    if (i_q == XW'(N_NEURON - 1)) state_d = S_ACT;
                    else                          i_d     = i_q + 1'b1;
                end else if (state_q == S_ACT) begin
                    state_d = S_WR;
                    i_d     = '0;
                end else if (state_q == S_WR) begin
                    if (o_q != XW'(N_NEURON - 1)) begin
                        o_d     = o_q + 1'b1;
                        state_d = S_MAC;
                    end else if (l_q != LW'(N_LAYER - 1)) begin
                        o_d     = '0;
                        l_d     = l_q + 1'b1;
                        state_d = S_MAC;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        w_addr_d   = '0;
        x_addr_d   = '0;
        y_addr_d   = '0;
        w_we_d     = 1'b0;
        mac_clr_d  = 1'b0;
        mac_en_d   = 1'b0;
        act_en_d   = 1'b0;
        y_we_d     = 1'b0;
        ack_fill_d = 1'b0;
        ack_net_d  = 1'b0;
        buf_sel_d  = l_d[0];

        case (state_d)
            S_FILL: begin
                w_we_d   = 1'b1;
                w_addr_d = fcnt_d;
            end
            S_FDONE: ack_fill_d = 1'b1;
            S_MAC: begin
                mac_en_d  = 1'b1;
                mac_clr_d = (i_d == '0);
                x_addr_d  = i_d;
                w_addr_d  = AW'(l_d) * AW'(N_NEURON * N_NEURON)
                          + AW'(o_d) * AW'(N_NEURON)
                          + AW'(i_d);
            end
            S_ACT: act_en_d = 1'b1;
            S_WR: begin
                y_we_d   = 1'b1;
                y_addr_d = o_d;
            end
            S_DONE: ack_net_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.w_addr      = w_addr_q;
    assign bus.w_we        = w_we_q;
    assign bus.x_addr      = x_addr_q;
    assign bus.mac_clr     = mac_clr_q;
    assign bus.mac_en      = mac_en_q;
    assign bus.act_en      = act_en_q;
    assign bus.y_we        = y_we_q;
    assign bus.y_addr      = y_addr_q;
    assign bus.buf_sel     = buf_sel_q;
    assign bus.ack_fill    = ack_fill_q;
    assign bus.ack_network = ack_net_q;
endmodule

// File: tb/tb_nn_sequencer.sv
// tb/tb_nn_sequencer.sv - randomized self-checking bench for nn_sequencer
module tb_nn_sequencer;
    localparam int N   = 4;
    localparam int L   = 2;
    localparam int AW  = 8;
    localparam int XW  = $clog2(N);
    localparam int NW  = L * N * N;
    localparam int RUN = L * N * (N + 2);
    localparam int OW  = AW + 2 * XW + 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    nn_sequencer_if #(.N_NEURON(N), .AW(AW)) bus ();

    nn_sequencer #(.N_NEURON(N), .N_LAYER(L), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit mac_en;
        bit mac_clr;
        bit act_en;
        bit y_we;
        bit buf_sel;
        int w_addr;
        int x_addr;
        int y_addr;
    } exp_t;

    exp_t model[$];

    // Expected per-cycle activity of one full inference, straight from the loop nest.
    function automatic void build_model();
        exp_t e;
        model.delete();
        for (int l = 0; l < L; l++) begin
            for (int o = 0; o < N; o++) begin
                for (int i = 0; i < N; i++) begin
                    e = '{1, (i == 0), 0, 0, (l % 2 == 1), l * N * N + o * N + i, i, 0};
                    model.push_back(e);
                end
                e = '{0, 0, 1, 0, (l % 2 == 1), 0, 0, 0};
                model.push_back(e);
                e = '{0, 0, 0, 1, (l % 2 == 1), 0, 0, o};
                model.push_back(e);
            end
        end
    endfunction

    function automatic logic [OW-1:0] all_outs();
        return {bus.ack_fill, bus.ack_network, bus.w_we, bus.mac_clr, bus.mac_en,
                bus.act_en, bus.y_we, bus.buf_sel, bus.w_addr, bus.x_addr, bus.y_addr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", all_outs());
        end
        rst = 1'b0;
    endtask

    task automatic test_fill(input bit req_noise);
        int hold;
        bus.fill = 1'b1;
        for (int a = 0; a < NW; a++) begin
            if (req_noise) bus.req = 1'(($urandom() % 2));
            step();
            checks++;
            if (bus.w_we !== 1'b1 || bus.w_addr !== AW'(a) || bus.ack_fill !== 1'b0 || bus.mac_en !== 1'b0) begin
                errors++;
                $display("FAIL fill_write %0d: got we=%b addr=%0d ack=%b mac_en=%b, expected we=1 addr=%0d ack=0 mac_en=0",
                         a, bus.w_we, bus.w_addr, bus.ack_fill, bus.mac_en, a);
            end
        end
        bus.req = 1'b0;
        hold = $urandom_range(1, 4);
        for (int h = 0; h < hold; h++) begin
            step();
            checks++;
            if (bus.ack_fill !== 1'b1 || bus.w_we !== 1'b0) begin
                errors++;
                $display("FAIL fill_ack: got ack=%b we=%b, expected ack=1 we=0", bus.ack_fill, bus.w_we);
            end
        end
        bus.fill = 1'b0;
        step();
        checks++;
        if (bus.ack_fill !== 1'b0 || bus.w_we !== 1'b0) begin
            errors++;
            $display("FAIL fill_release: got ack=%b we=%b, expected ack=0 we=0", bus.ack_fill, bus.w_we);
        end
    endtask

    task automatic test_compute(input bit fill_noise);
        exp_t e;
        int   clr_n, act_n, ywe_n, hold;
        logic [6:0] got, exp_v;
        clr_n = 0;
        act_n = 0;
        ywe_n = 0;
        bus.req = 1'b1;
        for (int c = 0; c < RUN; c++) begin
            if (fill_noise && c > 0) bus.fill = 1'(($urandom() % 2));
            step();
            e     = model[c];
            got   = {bus.mac_en, bus.mac_clr, bus.act_en, bus.y_we, bus.buf_sel, bus.w_we, bus.ack_network};
            exp_v = {e.mac_en, e.mac_clr, e.act_en, e.y_we, e.buf_sel, 1'b0, 1'b0};
            clr_n += int'(bus.mac_clr === 1'b1);
            act_n += int'(bus.act_en === 1'b1);
            ywe_n += int'(bus.y_we === 1'b1);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL compute_enables cycle %0d: got %b, expected %b (mac_en,clr,act,y_we,buf,w_we,ack)", c, got, exp_v);
            end
            if (e.mac_en) begin
                checks++;
                if (bus.w_addr !== AW'(e.w_addr) || bus.x_addr !== XW'(e.x_addr)) begin
                    errors++;
                    $display("FAIL compute_addr cycle %0d: got w=%0d x=%0d, expected w=%0d x=%0d",
                             c, bus.w_addr, bus.x_addr, e.w_addr, e.x_addr);
                end
            end
            if (e.y_we) begin
                checks++;
                if (bus.y_addr !== XW'(e.y_addr)) begin
                    errors++;
                    $display("FAIL compute_yaddr cycle %0d: got %0d, expected %0d", c, bus.y_addr, e.y_addr);
                end
            end
        end
        bus.fill = 1'b0;
        checks++;
        if (clr_n != L * N || act_n != L * N || ywe_n != L * N) begin
            errors++;
            $display("FAIL compute_counts: got clr=%0d act=%0d y_we=%0d, expected %0d each", clr_n, act_n, ywe_n, L * N);
        end
        hold = $urandom_range(1, 3);
        for (int h = 0; h < hold; h++) begin
            step();
            checks++;
            if (bus.ack_network !== 1'b1 || bus.mac_en !== 1'b0) begin
                errors++;
                $display("FAIL compute_ack: got ack=%b mac_en=%b, expected ack=1 mac_en=0", bus.ack_network, bus.mac_en);
            end
        end
        bus.req = 1'b0;
        step();
        checks++;
        if (bus.ack_network !== 1'b0 || bus.mac_en !== 1'b0) begin
            errors++;
            $display("FAIL compute_release: got ack=%b mac_en=%b, expected 0 0", bus.ack_network, bus.mac_en);
        end
    endtask

    task automatic test_simultaneous();
        bus.fill = 1'b1;
        bus.req  = 1'b1;
        for (int a = 0; a < 2; a++) begin
            step();
            checks++;
            if (bus.w_we !== 1'b1 || bus.mac_en !== 1'b0 || bus.w_addr !== AW'(a)) begin
                errors++;
                $display("FAIL simultaneous %0d: got we=%b mac_en=%b addr=%0d, expected we=1 mac_en=0 addr=%0d",
                         a, bus.w_we, bus.mac_en, bus.w_addr, a);
            end
        end
        bus.fill = 1'b0;
        bus.req  = 1'b0;
        step();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL simultaneous_abort: got %h, expected 0", all_outs());
        end
    endtask

    task automatic test_fill_abort(input int k);
        bus.fill = 1'b1;
        for (int a = 0; a <= k; a++) step();
        checks++;
        if (bus.w_we !== 1'b1 || bus.w_addr !== AW'(k)) begin
            errors++;
            $display("FAIL fill_abort_addr: got we=%b addr=%0d, expected we=1 addr=%0d", bus.w_we, bus.w_addr, k);
        end
        bus.fill = 1'b0;
        for (int h = 0; h < 2; h++) begin
            step();
            checks++;
            if (bus.w_we !== 1'b0 || bus.ack_fill !== 1'b0) begin
                errors++;
                $display("FAIL fill_abort_idle %0d: got we=%b ack=%b, expected 0 0", h, bus.w_we, bus.ack_fill);
            end
        end
    endtask

    task automatic test_req_abort();
        int k;
        do k = $urandom_range(0, RUN - 2); while (!model[k].mac_en);
        bus.req = 1'b1;
        for (int c = 0; c <= k; c++) step();
        checks++;
        if (bus.mac_en !== 1'b1) begin
            errors++;
            $display("FAIL req_abort_pre cycle %0d: got mac_en=%b, expected 1", k, bus.mac_en);
        end
        bus.req = 1'b0;
        step();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL req_abort: got %h, expected 0", all_outs());
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do k = $urandom_range(RUN / 2, RUN - 1); while (!model[k].mac_en);
        bus.req = 1'b1;
        for (int c = 0; c <= k; c++) step();
        checks++;
        if (bus.mac_en !== 1'b1 || bus.buf_sel !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre cycle %0d: got mac_en=%b buf_sel=%b, expected 1 1", k, bus.mac_en, bus.buf_sel);
        end
        rst = 1'b1;
        step();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %h, expected 0", all_outs());
        end
        rst = 1'b0;
        bus.req = 1'b0;
        step();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_mid_after: got %h, expected 0", all_outs());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fill = 1'b0;
        bus.req  = 1'b0;
        build_model();
        test_reset();
        test_fill(1'b0);
        test_compute(1'b0);
        test_simultaneous();
        test_fill_abort(10);
        test_fill(1'b1);
        test_fill_abort($urandom_range(1, NW - 2));
        test_fill(1'b0);
        test_req_abort();
        test_compute(1'b1);
        test_reset_mid();
        test_compute(1'b0);
        test_compute(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 Parameter N_NEURON, default 4, inputs per neuron and neurons per layer (square layers, >=2).
REQ-002 Parameter N_LAYER, default 2, number of linear+tanh layers (>=1).
REQ-003 Parameter AW, default 8, weight address width; AW >= clog2(N_LAYER*N_NEURON*N_NEURON).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 fill  input  1  level request to load weight memory.
REQ-007 req  input  1  level request to run the network.
REQ-008 ack_fill  output  1  weight load complete; held while fill=1.
REQ-009 ack_network  output  1  inference complete; held while req=1.
REQ-010 w_addr  output  AW  weight memory address (fill write and compute read).
REQ-011 w_we  output  1  weight memory write enable.
REQ-012 x_addr  output  clog2(N_NEURON)  input-buffer read index.
REQ-013 mac_clr  output  1  MAC loads product instead of accumulating.
REQ-014 mac_en  output  1  MAC operate enable.
REQ-015 act_en  output  1  tanh stage capture enable.
REQ-016 y_we  output  1  output-buffer write enable.
REQ-017 y_addr  output  clog2(N_NEURON)  output-buffer write index.
REQ-018 buf_sel  output  1  ping-pong select = LSB of current layer index.

Function
REQ-019 States: IDLE, FILL, FDONE, MAC, ACT, WR, DONE; one-hot or binary, implementer's choice.
REQ-020 IDLE: fill=1 -> FILL; else req=1 -> MAC; fill has priority when both are high.
REQ-021 FILL: w_we=1 every cycle, w_addr = fill counter, starting at 0, +1 per cycle.
REQ-022 FILL, counter = N_LAYER*N_NEURON^2-1 -> FDONE after that write; default: 32 writes, addresses 0..31.
REQ-023 FDONE: ack_fill=1, w_we=0; fill=0 -> IDLE the next cycle with ack_fill=0.
REQ-024 fill=0 during FILL: abort to IDLE, no ack_fill; the next fill restarts at address 0.
REQ-025 Compute counters: layer l, neuron o, input i; all are zero on entry to MAC from IDLE.
REQ-026 MAC: mac_en=1, mac_clr=1 only when i=0, x_addr=i, w_addr = l*N_NEURON^2 + o*N_NEURON + i.
REQ-027 MAC: i increments each cycle; after i=N_NEURON-1 -> ACT.
REQ-028 ACT: act_en=1 for exactly one cycle -> WR.
REQ-029 WR: y_we=1, y_addr=o for one cycle; i resets to 0.
REQ-030 WR, o<N_NEURON-1: o+1 -> MAC.
REQ-031 WR, o=N_NEURON-1 and l<N_LAYER-1: o=0, l+1 (buf_sel toggles) -> MAC.
REQ-032 WR, last neuron of last layer -> DONE.
REQ-033 Per-neuron latency N_NEURON+2 cycles; first MAC cycle to DONE = N_LAYER*N_NEURON*(N_NEURON+2) cycles (default 48).
REQ-034 DONE: ack_network=1; req=0 -> IDLE the next cycle with ack_network=0.
REQ-035 req=0 in MAC/ACT/WR: abort to IDLE; all enables 0 the next cycle; counters cleared.
REQ-036 fill is ignored outside IDLE/FILL/FDONE; req is ignored outside IDLE/compute/DONE.
REQ-037 All outputs registered; enables are 0 in every state not listed for them.

Reset
REQ-038 rst=1 at a clock edge: state IDLE; all counters 0; every output 0 (incl. buf_sel, w_addr, y_addr).
REQ-039 Reset overrides any state mid-operation; no write enable is asserted in the reset cycle or the cycle after.

Verification
REQ-040 Reset 2 cycles, fill=1 -> w_we high 32 cycles, w_addr 0..31, then ack_fill=1; fill=0 -> ack_fill=0 one cycle later.
REQ-041 After fill, req=1 -> 48 cycles of MAC/ACT/WR, then ack_network=1.
REQ-042 During the compute run of REQ-041: mac_clr high 8 times, act_en 8, y_we 8 with y_addr 0,1,2,3,0,1,2,3, buf_sel 0 then 1, w_addr 0..31 in order.
REQ-043 fill and req raised in the same cycle -> FILL entered, no mac_en.
REQ-044 fill dropped at address 10 -> IDLE with no ack_fill; next fill starts at w_addr 0.
REQ-045 rst pulsed during layer 1 MAC, and separately req dropped mid-MAC -> all outputs 0 next cycle; a fresh req completes in 48 cycles.
